// File: rtl/scc68070_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// scc68070_irq_ctrl_if
// Bundles every request, acknowledge and vector signal exchanged between the
// SCC68070 interrupt controller and the rest of the chip / CPU core.
//
//   in2, in4, in5          external level requests at fixed levels 2/4/5
//   int1, int2             interrupt inputs with programmable levels
//   lir_int1_ipl/_int2_ipl their levels (3 bits, 0 disables)
//   *_req / *_ipl          on-chip requests (timer, UART rx/tx, I2C) + levels
//   iack, ack_level        CPU acknowledge cycle and acknowledged level
//   ipl                    level presented to the CPU (active high)
//   autovector, vector,    vector response for the acknowledge cycle
//   vector_valid
//   *_clr / *_ack          one-cycle source-clear pulses
//
// slave  : the interrupt controller
// master : the surrounding chip / CPU side
// ---------------------------------------------------------------------------
interface scc68070_irq_ctrl_if;
    logic       in2;
    logic       in4;
    logic       in5;
    logic       int1;
    logic       int2;
    logic [2:0] lir_int1_ipl;
    logic [2:0] lir_int2_ipl;
    logic       timer_req;
    logic       uart_rx_req;
    logic       uart_tx_req;
    logic       i2c_req;
    logic [2:0] timer_ipl;
    logic [2:0] uart_rx_ipl;
    logic [2:0] uart_tx_ipl;
    logic [2:0] i2c_ipl;
    logic       iack;
    logic [2:0] ack_level;
    logic [2:0] ipl;
    logic       autovector;
    logic [7:0] vector;
    logic       vector_valid;
    logic       int1_clr;
    logic       int2_clr;
    logic       timer_ack;
    logic       uart_rx_ack;
    logic       uart_tx_ack;
    logic       i2c_ack;

    modport slave (
        input  in2, in4, in5, int1, int2, lir_int1_ipl, lir_int2_ipl,
               timer_req, uart_rx_req, uart_tx_req, i2c_req,
               timer_ipl, uart_rx_ipl, uart_tx_ipl, i2c_ipl,
               iack, ack_level,
        output ipl, autovector, vector, vector_valid,
               int1_clr, int2_clr, timer_ack, uart_rx_ack, uart_tx_ack, i2c_ack
    );

    modport master (
        output in2, in4, in5, int1, int2, lir_int1_ipl, lir_int2_ipl,
               timer_req, uart_rx_req, uart_tx_req, i2c_req,
               timer_ipl, uart_rx_ipl, uart_tx_ipl, i2c_ipl,
               iack, ack_level,
        input  ipl, autovector, vector, vector_valid,
               int1_clr, int2_clr, timer_ack, uart_rx_ack, uart_tx_ack, i2c_ack
    );
endinterface

// File: rtl/scc68070_irq_ctrl.sv
// ---------------------------------------------------------------------------
// scc68070_irq_ctrl
// Priority interrupt controller for the SCC68070: presents the highest
// pending level to the CPU, resolves the winning source when the CPU runs an
// acknowledge cycle, returns an (auto)vector and pulses the winner's clear.
//
// Ports
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    scc68070_irq_ctrl_if.slave (all requests, levels, ack, vector)
//
// Configuration macro
//   SCC_IRQ_INT_EDGE_EN  defined: int1/int2 are captured by rising-edge
//                        latches that stay pending until their clear pulse.
//                        undefined: int1/int2 are used as levels directly.
// ---------------------------------------------------------------------------
module scc68070_irq_ctrl (
    input  logic                  clk,
    input  logic                  reset,
    scc68070_irq_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

    state_t     state_q, state_d;
    logic       iackPrev_q;
    logic [2:0] ipl_q, ipl_d;
    logic [7:0] vector_q, vector_d;
    logic       autovector_q, autovector_d;
    logic       valid_q, valid_d;
    // bit k is the clear pulse of priority slot k+3 (int1 .. i2c)
    logic [5:0] pulse_q, pulse_d;

    logic       int1Req, int2Req;
    logic [8:0] srcReq;
    logic [2:0] srcLvl [9];
    logic [8:0] pending;
    logic [2:0] maxLvl;
    logic       winFound;
    logic [3:0] winIdx;
    logic       iackRise;

`ifdef SCC_IRQ_INT_EDGE_EN
    logic int1Prev_q, int2Prev_q, int1Lat_q, int2Lat_q;

    // A new edge wins over a clear issued in the same cycle so that no
    // request is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int1Prev_q <= 1'b0;
            int2Prev_q <= 1'b0;
            int1Lat_q  <= 1'b0;
            int2Lat_q  <= 1'b0;
        end else begin
            int1Prev_q <= bus.int1;
            int2Prev_q <= bus.int2;
            int1Lat_q  <= (int1Lat_q & ~pulse_d[0]) | (bus.int1 & ~int1Prev_q);
            int2Lat_q  <= (int2Lat_q & ~pulse_d[1]) | (bus.int2 & ~int2Prev_q);
        end
    end

    assign int1Req = int1Lat_q;
    assign int2Req = int2Lat_q;
`else
    assign int1Req = bus.int1;
    assign int2Req = bus.int2;
`endif

    // Sources listed in priority order within a level (slot 0 wins).
    always_comb begin
        srcReq    = {bus.i2c_req, bus.uart_tx_req, bus.uart_rx_req, bus.timer_req,
                     int2Req, int1Req, bus.in2, bus.in4, bus.in5};
        srcLvl[0] = 3'd5;
        srcLvl[1] = 3'd4;
        srcLvl[2] = 3'd2;
        srcLvl[3] = bus.lir_int1_ipl;
        srcLvl[4] = bus.lir_int2_ipl;
        srcLvl[5] = bus.timer_ipl;
        srcLvl[6] = bus.uart_rx_ipl;
        srcLvl[7] = bus.uart_tx_ipl;
        srcLvl[8] = bus.i2c_ipl;
    end

    // Level 0 disables a source, which also makes ack_level 0 spurious.
    always_comb begin
        pending  = '0;
        maxLvl   = 3'd0;
        winFound = 1'b0;
        winIdx   = 4'd0;
        for (int i = 0; i < 9; i++) begin
            pending[i] = srcReq[i] && (srcLvl[i] != 3'd0);
            if (pending[i] && (srcLvl[i] > maxLvl))
                maxLvl = srcLvl[i];
            if (!winFound && pending[i] && (srcLvl[i] == bus.ack_level)) begin
                winFound = 1'b1;
                winIdx   = 4'(i);
            end
        end
    end

    assign iackRise = bus.iack & ~iackPrev_q;

    // State register plus the registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            iackPrev_q   <= 1'b0;
            ipl_q        <= 3'd0;
            vector_q     <= 8'd0;
            autovector_q <= 1'b0;
            valid_q      <= 1'b0;
            pulse_q      <= 6'd0;
        end else begin
            state_q      <= state_d;
            iackPrev_q   <= bus.iack;
            ipl_q        <= ipl_d;
            vector_q     <= vector_d;
            autovector_q <= autovector_d;
            valid_q      <= valid_d;
            pulse_q      <= pulse_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iackRise) state_d = ACK;
            ACK:     state_d = HOLD;
            HOLD:    if (!bus.iack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: ipl tracks pending only in IDLE; the vector and the
    // winner's clear pulse are launched on the ACK->HOLD edge.
    always_comb begin
        ipl_d        = ipl_q;
        vector_d     = vector_q;
        autovector_d = autovector_q;
        valid_d      = valid_q;
        pulse_d      = 6'd0;
        case (state_q)
            IDLE: ipl_d = maxLvl;
            ACK: begin
                valid_d = 1'b1;
                if (!winFound) begin
                    autovector_d = 1'b0;
                    vector_d     = 8'd24;
                end else if (winIdx <= 4'd4) begin
                    autovector_d = 1'b1;
                    vector_d     = 8'd24 + {5'd0, bus.ack_level};
                end else begin
                    autovector_d = 1'b0;
                    vector_d     = 8'd56 + {5'd0, bus.ack_level};
                end
                for (int k = 0; k < 6; k++)
                    if (winFound && (winIdx == 4'(k + 3)))
                        pulse_d[k] = 1'b1;
            end
            HOLD: if (!bus.iack) valid_d = 1'b0;
            default: ;
        endcase
    end

    assign bus.ipl          = ipl_q;
    assign bus.vector       = vector_q;
    assign bus.autovector   = autovector_q;
    assign bus.vector_valid = valid_q;
    assign bus.int1_clr     = pulse_q[0];
    assign bus.int2_clr     = pulse_q[1];
    assign bus.timer_ack    = pulse_q[2];
    assign bus.uart_rx_ack  = pulse_q[3];
    assign bus.uart_tx_ack  = pulse_q[4];
    assign bus.i2c_ack      = pulse_q[5];

endmodule

// File: doc/scc68070_irq_ctrl.md
SCC68070_IRQ_CTRL -- requirements
Module: scc68070_irq_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; reset  in  1  asynchronous, active-high.
REQ-002 SHALL have ports: in2, in4, in5  in  1 each  external level requests at fixed levels 2/4/5.
REQ-003 SHALL have ports: int1, int2  in  1 each  latched interrupt inputs; lir_int1_ipl, lir_int2_ipl  in  3 each  their levels.
REQ-004 SHALL have ports: timer_req, uart_rx_req, uart_tx_req, i2c_req  in  1 each; timer_ipl, uart_rx_ipl, uart_tx_ipl, i2c_ipl  in  3 each  on-chip requests and PICR levels.
REQ-005 SHALL have ports: iack  in  1  CPU interrupt-acknowledge cycle active (FC=111 with strobe); ack_level  in  3  acknowledged level (A3:A1).
REQ-006 SHALL have ports: ipl  out  3  active-high level presented to CPU; autovector  out  1; vector  out  8  vector number; vector_valid  out  1.
REQ-007 SHALL have ports: int1_clr, int2_clr, timer_ack, uart_rx_ack, uart_tx_ack, i2c_ack  out  1 each  one-cycle source-clear pulses.

Function
REQ-008 A source SHALL be pending when its request is 1 and its level is nonzero; level 0 disables it.
REQ-009 ipl SHALL be registered: the highest level among pending sources, 0 if none, updated every clock in IDLE (1-cycle latency from request change).
REQ-010 Within one level, priority SHALL be in5, in4, in2, int1, int2, timer, uart_rx, uart_tx, i2c (first wins).
REQ-011 FSM states: IDLE, ACK, HOLD.
REQ-012 IDLE->ACK on rising edge of iack; in ACK (exactly one cycle) the winner at ack_level SHALL be resolved from current pending state, not the presented ipl.
REQ-013 Winner external (in2/4/5) or int1/int2: autovector=1, vector=24+ack_level; on-chip winner: autovector=0, vector=56+ack_level (timer at level 6 yields 62).
REQ-014 No pending source at ack_level: spurious, autovector=0, vector=24, no clear pulse.
REQ-015 ACK->HOLD: vector, autovector, vector_valid=1 SHALL be registered on the ACK->HOLD edge and held stable through HOLD; exactly one clear/ack pulse for the winner in that same cycle.
REQ-016 ipl SHALL be frozen during ACK and HOLD; HOLD->IDLE when iack=0, vector_valid drops the same edge.
REQ-017 in2/in4/in5 SHALL receive no clear pulse (level sources, cleared externally).
REQ-018 A request arriving during ACK/HOLD SHALL be held pending and presented once back in IDLE; none lost.
REQ-019 ack_level=0 SHALL be treated as spurious.

Reset
REQ-020 Asynchronous reset SHALL force state IDLE, ipl=0, autovector=0, vector=0, vector_valid=0, all pulses 0, edge latches 0.
REQ-021 Reset mid-acknowledge SHALL abort without emitting any clear pulse; first post-reset cycle behaves as IDLE.

Configuration
REQ-022 Macro SCC_IRQ_INT_EDGE_EN defined: int1/int2 SHALL be captured by internal rising-edge latches, pending until int1_clr/int2_clr; level input ignored otherwise.
REQ-023 Macro undefined: int1/int2 SHALL be used as levels directly; int1_clr/int2_clr still pulse on acknowledge.

Verification
REQ-024 timer_req=1, timer_ipl=6 -> ipl=6 after 1 clk; iack, ack_level=6 -> vector=62, autovector=0, timer_ack single pulse.
REQ-025 in4=1 and uart_rx_req=1 with uart_rx_ipl=4 -> ack level 4 picks in4: autovector=1, vector=28, no uart_rx_ack.
REQ-026 in5=1 and timer at level 3 -> ipl=5; drop in5 before iack, ack_level=5 -> spurious vector=24, no pulses.
REQ-027 Assert i2c_req (level 2) during HOLD -> ipl unchanged until iack=0, then ipl=2 next clk.
REQ-028 reset asserted in ACK -> all outputs 0 immediately, no pulses; with SCC_IRQ_INT_EDGE_EN, int1 pulse 1 clk at level 7 -> ipl=7 held until acknowledged, int1_clr pulses, then ipl=0.
